// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit with architectural HI/LO.
// The result is computed on acceptance and held pending until the modelled latency expires.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   hi_q, lo_q;
   logic [31:0]   pend_hi_q, pend_lo_q;
   logic          pend_wr_q;

   logic [31:0]   pend_hi_d, pend_lo_d;
   logic          pend_wr_d;
   logic [CW-1:0] cnt_load;

   logic          is_md;
   logic          is_div_op;
   logic          a_neg, b_neg;
   logic [31:0]   dvd, dvs, quo, rem;
   logic [63:0]   prod_s, prod_u;

   assign busy  = (state_q == ST_BUSY);
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign is_md = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                  (md_op == OP_DIV)  || (md_op == OP_DIVU);
   assign start = md_valid && is_md && !busy;
   assign is_div_op = (md_op == OP_DIV) || (md_op == OP_DIVU);

   assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
   assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

   // One unsigned divider serves both DIV and DIVU; signed DIV works on magnitudes,
   // which also makes 0x80000000 / -1 wrap to 0x80000000 without special casing.
   assign a_neg = (md_op == OP_DIV) && rs_data[31];
   assign b_neg = (md_op == OP_DIV) && rt_data[31];
   assign dvd   = a_neg ? (32'd0 - rs_data) : rs_data;
   assign dvs   = (rt_data == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - rt_data) : rt_data);
   assign quo   = dvd / dvs;
   assign rem   = dvd % dvs;

   always_comb begin
      pend_hi_d = 32'd0;
      pend_lo_d = 32'd0;
      pend_wr_d = 1'b1;
      cnt_load  = CW'(MULT_CYCLES);
      case (md_op)
         OP_MULT: begin
            pend_hi_d = prod_s[63:32];
            pend_lo_d = prod_s[31:0];
         end
         OP_MULTU: begin
            pend_hi_d = prod_u[63:32];
            pend_lo_d = prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            pend_lo_d = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
            pend_hi_d = a_neg ? (32'd0 - rem) : rem;
            pend_wr_d = (rt_data != 32'd0);
         end
         default: ;
      endcase
      if (is_div_op) cnt_load = CW'(DIV_CYCLES);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q   <= ST_BUSY;
                  cnt_q     <= cnt_load;
                  pend_hi_q <= pend_hi_d;
                  pend_lo_q <= pend_lo_d;
                  pend_wr_q <= pend_wr_d;
               end else if (md_valid && md_op == OP_MTHI) begin
                  hi_q <= rs_data;
               end else if (md_valid && md_op == OP_MTLO) begin
                  lo_q <= rs_data;
               end
            end
            ST_BUSY: begin
               // Any MD op arriving here is ignored; the hazard unit should have stalled it.
               if (cnt_q == CW'(1)) begin
                  state_q   <= ST_IDLE;
                  cnt_q     <= '0;
                  pend_wr_q <= 1'b0;
                  if (pend_wr_q) begin
                     hi_q <= pend_hi_q;
                     lo_q <= pend_lo_q;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: random and directed MD ops against a longint arithmetic model;
// a monitor compares HI/LO and busy length each time busy drops.
module tb_md_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_valid;
   logic [2:0]  md_op;
   logic [31:0] rs_data, rt_data;
   logic        start, busy;
   logic [31:0] hi, lo;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
      .rs_data(rs_data), .rt_data(rt_data),
      .start(start), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int free_at = 0;
   logic [31:0] m_hi = 0, m_lo = 0;
   logic [71:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; returns {hi,lo} after the op.
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] ch,
                                          input logic [31:0] cl);
      longint sa, sb, sq, sr;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: begin sq = sa * sb; return sq; end
         3'd2: begin up = ua * ub; return up; end
         3'd3: begin
            if (b == 0) return {ch, cl};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         3'd4: begin
            if (b == 0) return {ch, cl};
            up = ua / ub;
            ua = ua % ub;
            return {ua[31:0], up[31:0]};
         end
         default: return {ch, cl};
      endcase
   endfunction

   // Monitor: count busy cycles, compare on the cycle busy drops.
   initial begin
      int run;
      logic [71:0] e;
      run = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) run++;
         else begin
            if (run > 0 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("done_hi", hi, e[63:32]);
               check("done_lo", lo, e[31:0]);
               check("busy_len", 32'(run), {24'd0, e[71:64]});
            end
            run = 0;
         end
      end
   end

   // One cycle: drive at posedge+1, check start at negedge, return at next posedge+1.
   task automatic step(input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit exp_start, mt;
      logic [63:0] r;
      md_valid = v; md_op = op; rs_data = a; rt_data = b;
      @(negedge clk);
      exp_start = v && op >= 3'd1 && op <= 3'd4 && (cyc + 1 >= free_at);
      mt = v && (op == 3'd5 || op == 3'd6) && (cyc + 1 >= free_at);
      check("start", {31'd0, start}, {31'd0, exp_start});
      if (exp_start) begin
         r = ref_md(op, a, b, m_hi, m_lo);
         exp_q.push_back({((op >= 3'd3) ? 8'(DC) : 8'(MC)), r});
         m_hi = r[63:32];
         m_lo = r[31:0];
         free_at = cyc + 1 + ((op >= 3'd3) ? DC : MC) + 1;
      end else if (mt) begin
         if (op == 3'd5) m_hi = a; else m_lo = a;
      end
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      if (mt) begin
         check("mt_hi", hi, m_hi);
         check("mt_lo", lo, m_lo);
         check("mt_busy", {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (cyc + 1 < free_at && guard < 200) begin
         step(0, 3'd0, 32'd0, 32'd0);
         guard++;
      end
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      md_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      m_hi = 0;
      m_lo = 0;
      free_at = 0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] saved_lo;
      reset = 1'b1; md_valid = 1'b0; md_op = 3'd0; rs_data = 0; rt_data = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // 1: signed multiply
      step(1, 3'd1, 32'hFFFF_FFFD, 32'd5);
      wait_idle();
      check("t1_hi", hi, 32'hFFFF_FFFF);
      check("t1_lo", lo, 32'hFFFF_FFF1);

      // 2: unsigned multiply
      step(1, 3'd2, 32'hFFFF_FFFF, 32'd2);
      wait_idle();
      check("t2_hi", hi, 32'h0000_0001);
      check("t2_lo", lo, 32'hFFFF_FFFE);

      // 3: signed divide, then unsigned divide
      step(1, 3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      check("t3_hi", hi, 32'hFFFF_FFFF);
      check("t3_lo", lo, 32'hFFFF_FFFD);
      step(1, 3'd4, 32'd7, 32'd2);
      wait_idle();
      check("t3u_hi", hi, 32'd1);
      check("t3u_lo", lo, 32'd3);

      // overflow divide
      step(1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      check("ovf_hi", hi, 32'd0);
      check("ovf_lo", lo, 32'h8000_0000);

      // 4: MTHI then divide by zero
      saved_lo = m_lo;
      step(1, 3'd5, 32'h1234, 32'd0);
      step(1, 3'd4, 32'd7, 32'd0);
      wait_idle();
      check("t4_hi", hi, 32'h1234);
      check("t4_lo", lo, saved_lo);

      // 5: ops during busy are ignored, back-to-back start on busy drop
      do_reset();
      step(1, 3'd1, 32'd2, 32'd3);
      step(1, 3'd6, 32'hAAAA, 32'd0);
      step(1, 3'd3, 32'd9, 32'd2);
      while (cyc + 1 < free_at) step(0, 3'd0, 32'd0, 32'd0);
      step(1, 3'd1, 32'd4, 32'd5);
      check("t5_hi", hi, 32'd0);
      check("t5_lo", lo, 32'd6);
      wait_idle();

      // 6: reset in 3rd busy cycle aborts the divide
      step(1, 3'd3, 32'd100, 32'd7);
      step(0, 3'd0, 32'd0, 32'd0);
      step(0, 3'd0, 32'd0, 32'd0);
      do_reset();
      repeat (DC + 3) step(0, 3'd0, 32'd0, 32'd0);
      check("t6_hi", hi, 32'd0);
      check("t6_lo", lo, 32'd0);

      // random traffic, including ops issued while busy
      for (int i = 0; i < 80; i++) begin
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick());
      end
      wait_idle();
      check("final_hi", hi, m_hi);
      check("final_lo", lo, m_lo);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
